// File: rtl/ctrl_alu_exmem_slice.sv
// rtl/ctrl_alu_exmem_slice.sv - MIPS main decoder, EX-stage ALU and EX/MEM pipeline register
module ctrl_alu_exmem_slice (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        RegDst,
  output logic [1:0]  PCSrc,
  output logic        MemR,
  output logic        Mem2R,
  output logic        MemW,
  output logic        RegW,
  output logic        Alusrc,
  output logic [1:0]  EXTOp,
  output logic [4:0]  Aluctrl,
  output logic        PCWr,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUOp,
  input  logic [4:0]  sa,
  output logic [31:0] C,
  output logic        Zero,
  input  logic        flush,
  input  logic [31:0] PCin,
  input  logic [31:0] RD2,
  input  logic [5:0]  Op,
  input  logic [4:0]  RD,
  input  logic [1:0]  pcsrc_i,
  input  logic        memr_i,
  input  logic        memw_i,
  input  logic        regw_i,
  input  logic        mem2r_i,
  input  logic        pcwr_i,
  output logic [31:0] PCout,
  output logic [31:0] aluout,
  output logic [31:0] rd2,
  output logic [5:0]  op,
  output logic [4:0]  rd,
  output logic [1:0]  pcsrc,
  output logic        memr,
  output logic        memw,
  output logic        regw,
  output logic        mem2r,
  output logic        pcwr
);

  logic legal;

  // Main decoder: fields are built per instruction, then zeroed as a bubble when illegal
  always_comb begin
    legal   = 1'b1;
    RegDst  = 1'b0;
    PCSrc   = 2'b00;
    MemR    = 1'b0;
    Mem2R   = 1'b0;
    MemW    = 1'b0;
    RegW    = 1'b0;
    Alusrc  = 1'b0;
    EXTOp   = 2'b00;
    Aluctrl = 5'd0;
    case (opcode)
      6'h00: begin
        RegW = 1'b1;
        case (funct)
          6'h20, 6'h21: Aluctrl = 5'd0;
          6'h22, 6'h23: Aluctrl = 5'd1;
          6'h24:        Aluctrl = 5'd2;
          6'h25:        Aluctrl = 5'd3;
          6'h26:        Aluctrl = 5'd4;
          6'h27:        Aluctrl = 5'd5;
          6'h2A:        Aluctrl = 5'd6;
          6'h2B:        Aluctrl = 5'd7;
          6'h00:        Aluctrl = 5'd8;
          6'h02:        Aluctrl = 5'd9;
          6'h03:        Aluctrl = 5'd10;
          6'h04:        Aluctrl = 5'd11;
          6'h06:        Aluctrl = 5'd12;
          6'h07:        Aluctrl = 5'd13;
          6'h08: begin
            RegW  = 1'b0;
            PCSrc = 2'b11;
          end
          default:      legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b01; Aluctrl = 5'd0; end
      6'h0A:        begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b01; Aluctrl = 5'd6; end
      6'h0B:        begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b01; Aluctrl = 5'd7; end
      6'h0C:        begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; Aluctrl = 5'd2; end
      6'h0D:        begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; Aluctrl = 5'd3; end
      6'h0E:        begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; Aluctrl = 5'd4; end
      6'h0F:        begin RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b10; Aluctrl = 5'd14; end
      6'h23: begin
        RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b01;
        MemR = 1'b1; Mem2R = 1'b1;
      end
      6'h2B:        begin RegDst = 1'b1; Alusrc = 1'b1; EXTOp = 2'b01; MemW = 1'b1; end
      6'h04:        begin RegDst = 1'b1; EXTOp = 2'b01; Aluctrl = 5'd1; PCSrc = 2'b01; end
      6'h05:        begin RegDst = 1'b1; EXTOp = 2'b01; Aluctrl = 5'd1; PCSrc = 2'b10; end
      6'h02:        PCSrc = 2'b11;
      6'h03:        begin PCSrc = 2'b11; RegW = 1'b1; end
      default:      legal = 1'b0;
    endcase
    PCWr = legal;
    if (!legal) begin
      RegDst  = 1'b0;
      PCSrc   = 2'b00;
      MemR    = 1'b0;
      Mem2R   = 1'b0;
      MemW    = 1'b0;
      RegW    = 1'b0;
      Alusrc  = 1'b0;
      EXTOp   = 2'b00;
      Aluctrl = 5'd0;
    end
  end

  // ALU: wrapping arithmetic, shifts by sa or by A[4:0], unused codes give zero
  always_comb begin
    C = 32'd0;
    case (ALUOp)
      5'd0:  C = A + B;
      5'd1:  C = A - B;
      5'd2:  C = A & B;
      5'd3:  C = A | B;
      5'd4:  C = A ^ B;
      5'd5:  C = ~(A | B);
      5'd6:  C = {31'd0, $signed(A) < $signed(B)};
      5'd7:  C = {31'd0, A < B};
      5'd8:  C = B << sa;
      5'd9:  C = B >> sa;
      5'd10: C = $unsigned($signed(B) >>> sa);
      5'd11: C = B << A[4:0];
      5'd12: C = B >> A[4:0];
      5'd13: C = $unsigned($signed(B) >>> A[4:0]);
      5'd14: C = B;
      default: C = 32'd0;
    endcase
    Zero = (C == 32'd0);
  end

  // EX/MEM register: reset and flush both clear the entry, otherwise capture EX results
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      PCout  <= 32'd0;
      aluout <= 32'd0;
      rd2    <= 32'd0;
      op     <= 6'd0;
      rd     <= 5'd0;
      pcsrc  <= 2'b00;
      memr   <= 1'b0;
      memw   <= 1'b0;
      regw   <= 1'b0;
      mem2r  <= 1'b0;
      pcwr   <= 1'b0;
    end else begin
      PCout  <= PCin;
      aluout <= C;
      rd2    <= RD2;
      op     <= Op;
      rd     <= RD;
      pcsrc  <= pcsrc_i;
      memr   <= memr_i;
      memw   <= memw_i;
      regw   <= regw_i;
      mem2r  <= mem2r_i;
      pcwr   <= pcwr_i;
    end
  end

endmodule

// File: tb/tb_ctrl_alu_exmem_slice.sv
// tb/tb_ctrl_alu_exmem_slice.sv - scoreboard bench for ctrl_alu_exmem_slice
module tb_ctrl_alu_exmem_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        RegDst, MemR, Mem2R, MemW, RegW, Alusrc, PCWr;
  logic [1:0]  PCSrc, EXTOp;
  logic [4:0]  Aluctrl;
  logic [31:0] A, B, C;
  logic [4:0]  ALUOp, sa;
  logic        Zero;
  logic        flush;
  logic [31:0] PCin, RD2;
  logic [5:0]  Op;
  logic [4:0]  RD;
  logic [1:0]  pcsrc_i;
  logic        memr_i, memw_i, regw_i, mem2r_i, pcwr_i;
  logic [31:0] PCout, aluout, rd2;
  logic [5:0]  op;
  logic [4:0]  rd;
  logic [1:0]  pcsrc;
  logic        memr, memw, regw, mem2r, pcwr;

  ctrl_alu_exmem_slice dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .RegDst(RegDst), .PCSrc(PCSrc), .MemR(MemR), .Mem2R(Mem2R), .MemW(MemW),
    .RegW(RegW), .Alusrc(Alusrc), .EXTOp(EXTOp), .Aluctrl(Aluctrl), .PCWr(PCWr),
    .A(A), .B(B), .ALUOp(ALUOp), .sa(sa), .C(C), .Zero(Zero),
    .flush(flush), .PCin(PCin), .RD2(RD2), .Op(Op), .RD(RD),
    .pcsrc_i(pcsrc_i), .memr_i(memr_i), .memw_i(memw_i), .regw_i(regw_i),
    .mem2r_i(mem2r_i), .pcwr_i(pcwr_i),
    .PCout(PCout), .aluout(aluout), .rd2(rd2), .op(op), .rd(rd),
    .pcsrc(pcsrc), .memr(memr), .memw(memw), .regw(regw), .mem2r(mem2r), .pcwr(pcwr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    string        name;
    logic [127:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] dv(input logic regdst, input logic [1:0] pcs, input logic mr,
                                     input logic m2r, input logic mw, input logic rw, input logic as,
                                     input logic [1:0] ext, input logic [4:0] ac, input logic pw);
    return {regdst, pcs, mr, m2r, mw, rw, as, ext, ac, pw};
  endfunction

  function automatic logic [113:0] rv(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] d2,
                                      input logic [5:0] o, input logic [4:0] r, input logic [1:0] pcs,
                                      input logic mr, input logic mw, input logic rw, input logic m2r,
                                      input logic pw);
    return {pc, alu, d2, o, r, pcs, mr, mw, rw, m2r, pw};
  endfunction

  // Monitor: at each falling edge, compare every pending expectation against the DUT
  exp_t         e;
  logic [127:0] act;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = {112'd0, RegDst, PCSrc, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl, PCWr};
        1:       act = {95'd0, Zero, C};
        default: act = {14'd0, PCout, aluout, rd2, op, rd, pcsrc, memr, memw, regw, mem2r, pcwr};
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic dec(input logic [5:0] o, input logic [5:0] f, input logic [15:0] v, input string n);
    @(posedge clk); #1;
    opcode = o;
    funct  = f;
    q.push_back('{0, n, {112'd0, v}});
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] aop,
                     input logic [4:0] s, input logic [31:0] c, input logic z, input string n);
    @(posedge clk); #1;
    A = a; B = b; ALUOp = aop; sa = s;
    q.push_back('{1, n, {95'd0, z, c}});
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] aop, input logic [31:0] d2, input logic [5:0] o,
                          input logic [4:0] r, input logic [1:0] pcs, input logic [4:0] ctl);
    PCin = pc; A = a; B = b; ALUOp = aop; sa = 5'd0; RD2 = d2; Op = o; RD = r;
    pcsrc_i = pcs;
    {memr_i, memw_i, regw_i, mem2r_i, pcwr_i} = ctl;
  endtask

  task automatic expect_reg(input logic [113:0] v, input string n);
    q.push_back('{2, n, {14'd0, v}});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; opcode = 6'h3F; funct = 6'h3F;
    drive_ex(32'h1234, 32'd1, 32'd2, 5'd0, 32'hAAAA, 6'h23, 5'd7, 2'b11, 5'b11111);
    @(posedge clk); @(posedge clk); #1;
    expect_reg(114'd0, "reset_state");

    // Decoder
    dec(6'h23, 6'h00, dv(1, 2'b00, 1, 1, 0, 1, 1, 2'b01, 5'd0, 1), "dec_lw");
    dec(6'h3F, 6'h00, 16'd0, "dec_illegal_op");
    dec(6'h00, 6'h2A, dv(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 5'd6, 1), "dec_slt");
    dec(6'h00, 6'h08, dv(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 5'd0, 1), "dec_jr");
    dec(6'h00, 6'h3F, 16'd0, "dec_illegal_funct");
    dec(6'h00, 6'h03, dv(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 5'd10, 1), "dec_sra");
    dec(6'h00, 6'h06, dv(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 5'd12, 1), "dec_srlv");
    dec(6'h00, 6'h23, dv(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 5'd1, 1), "dec_subu");
    dec(6'h2B, 6'h00, dv(1, 2'b00, 0, 0, 1, 0, 1, 2'b01, 5'd0, 1), "dec_sw");
    dec(6'h04, 6'h00, dv(1, 2'b01, 0, 0, 0, 0, 0, 2'b01, 5'd1, 1), "dec_beq");
    dec(6'h05, 6'h00, dv(1, 2'b10, 0, 0, 0, 0, 0, 2'b01, 5'd1, 1), "dec_bne");
    dec(6'h0F, 6'h00, dv(1, 2'b00, 0, 0, 0, 1, 1, 2'b10, 5'd14, 1), "dec_lui");
    dec(6'h0D, 6'h00, dv(1, 2'b00, 0, 0, 0, 1, 1, 2'b00, 5'd3, 1), "dec_ori");
    dec(6'h0B, 6'h00, dv(1, 2'b00, 0, 0, 0, 1, 1, 2'b01, 5'd7, 1), "dec_sltiu");
    dec(6'h09, 6'h00, dv(1, 2'b00, 0, 0, 0, 1, 1, 2'b01, 5'd0, 1), "dec_addiu");
    dec(6'h02, 6'h00, dv(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 5'd0, 1), "dec_j");
    dec(6'h03, 6'h00, dv(0, 2'b11, 0, 0, 0, 1, 0, 2'b00, 5'd0, 1), "dec_jal");

    // ALU
    alu(32'hFFFFFFFF, 32'd1,        5'd0,  5'd0,  32'd0,        1'b1, "alu_add_wrap");
    alu(32'h80000000, 32'd1,        5'd6,  5'd0,  32'd1,        1'b0, "alu_slt");
    alu(32'h80000000, 32'd1,        5'd7,  5'd0,  32'd0,        1'b1, "alu_sltu");
    alu(32'd5,        32'd5,        5'd1,  5'd0,  32'd0,        1'b1, "alu_sub_zero");
    alu(32'd3,        32'd5,        5'd1,  5'd0,  32'hFFFFFFFE, 1'b0, "alu_sub_neg");
    alu(32'hC,        32'hA,        5'd2,  5'd0,  32'h8,        1'b0, "alu_and");
    alu(32'hC,        32'hA,        5'd3,  5'd0,  32'hE,        1'b0, "alu_or");
    alu(32'hF0F0F0F0, 32'hFF00FF00, 5'd4,  5'd0,  32'h0FF00FF0, 1'b0, "alu_xor");
    alu(32'd0,        32'd0,        5'd5,  5'd0,  32'hFFFFFFFF, 1'b0, "alu_nor");
    alu(32'd0,        32'd1,        5'd8,  5'd31, 32'h80000000, 1'b0, "alu_sll");
    alu(32'd0,        32'h80000000, 5'd9,  5'd4,  32'h08000000, 1'b0, "alu_srl");
    alu(32'd0,        32'h80000000, 5'd10, 5'd4,  32'hF8000000, 1'b0, "alu_sra");
    alu(32'd36,       32'd1,        5'd11, 5'd0,  32'h10,       1'b0, "alu_sllv");
    alu(32'd33,       32'h100,      5'd12, 5'd0,  32'h80,       1'b0, "alu_srlv");
    alu(32'd4,        32'h80000000, 5'd13, 5'd0,  32'hF8000000, 1'b0, "alu_srav");
    alu(32'd7,        32'h12340000, 5'd14, 5'd0,  32'h12340000, 1'b0, "alu_passb");
    alu(32'd7,        32'd9,        5'd20, 5'd3,  32'd0,        1'b1, "alu_unused_op");

    // EX/MEM register
    @(posedge clk); #1;
    rst = 1'b0;
    drive_ex(32'h400, 32'd3, 32'd4, 5'd0, 32'hDEAD, 6'h23, 5'd9, 2'b10, 5'b10111);
    @(posedge clk); #1;
    expect_reg(rv(32'h400, 32'd7, 32'hDEAD, 6'h23, 5'd9, 2'b10, 1, 0, 1, 1, 1), "reg_load");
    #2;
    drive_ex(32'h800, 32'd10, 32'd20, 5'd1, 32'hBEEF, 6'h2B, 5'd3, 2'b01, 5'b01001);
    expect_reg(rv(32'h400, 32'd7, 32'hDEAD, 6'h23, 5'd9, 2'b10, 1, 0, 1, 1, 1), "reg_stable");
    @(posedge clk); #1;
    expect_reg(rv(32'h800, 32'hFFFFFFF6, 32'hBEEF, 6'h2B, 5'd3, 2'b01, 0, 1, 0, 0, 1), "reg_load2");
    flush = 1'b1;
    @(posedge clk); #1;
    expect_reg(114'd0, "reg_flush");
    flush = 1'b0;
    @(posedge clk); #1;
    expect_reg(rv(32'h800, 32'hFFFFFFF6, 32'hBEEF, 6'h2B, 5'd3, 2'b01, 0, 1, 0, 0, 1), "reg_after_flush");
    rst = 1'b1;
    @(posedge clk); #1;
    expect_reg(114'd0, "reg_reset_mid");
    flush = 1'b1;
    @(posedge clk); #1;
    expect_reg(114'd0, "reg_reset_and_flush");
    rst = 1'b0; flush = 1'b0;
    drive_ex(32'hC, 32'h10, 32'h2, 5'd11, 32'h5, 6'h00, 5'd31, 2'b11, 5'b00101);
    @(posedge clk); #1;
    expect_reg(rv(32'hC, 32'h00020000, 32'h5, 6'h00, 5'd31, 2'b11, 0, 0, 1, 0, 1), "reg_after_release");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_alu_exmem_slice.md
Name: ctrl_alu_exmem_slice

Overview:
Combines three datapath pieces of the 5-stage MIPS pipeline. A combinational main decoder (ID stage) maps opcode/funct to control signals. A combinational ALU (EX stage) computes the result and the Zero flag. The EX/MEM pipeline register latches the ALU result plus the EX-stage control and data fields for the MEM stage.

Parameters:
none (32-bit datapath, 5-bit ALU op, 5-bit register index are fixed)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, synchronous, active-high
opcode  in  6  ID instruction [31:26]
funct  in  6  ID instruction [5:0]
RegDst  out  1  1 = dest is rt, 0 = dest is rd
PCSrc  out  2  00 seq, 01 beq, 10 bne, 11 jump (j/jal/jr)
MemR  out  1  load
Mem2R  out  1  writeback selects memory data
MemW  out  1  store
RegW  out  1  register write
Alusrc  out  1  1 = ALU B from immediate
EXTOp  out  2  00 zero-ext, 01 sign-ext, 10 imm16<<16
Aluctrl  out  5  ALU operation
PCWr  out  1  1 = decoded (legal) instruction
A  in  32  ALU operand A
B  in  32  ALU operand B
ALUOp  in  5  EX-stage ALU operation
sa  in  5  shift amount
C  out  32  ALU result (combinational)
Zero  out  1  C == 0
flush  in  1  squash the EX/MEM entry
PCin, RD2  in  32  EX PC, store data
Op  in  6  EX opcode
RD  in  5  EX destination register
pcsrc_i, memr_i, memw_i, regw_i, mem2r_i, pcwr_i  in  2/1/1/1/1/1  EX controls
PCout, aluout, rd2  out  32  registered PCin, C, RD2
op  out  6  registered Op
rd  out  5  registered RD
pcsrc, memr, memw, regw, mem2r, pcwr  out  2/1/1/1/1/1  registered controls

Behaviour:
- ALU ops (ALUOp):
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOR
  - 6 SLT signed (C = 1/0); 7 SLTU unsigned
  - 8 SLL B<<sa; 9 SRL B>>sa; 10 SRA B>>>sa
  - 11 SLLV B<<A[4:0]; 12 SRLV; 13 SRAV
  - 14 PASSB C=B
  - 15-31: C=0
- ALU arithmetic: wraps mod 2^32, no overflow trap. Zero = (C==0).
- Decoder, R-type (opcode 0): RegDst=0, RegW=1, Alusrc=0, PCSrc=00.
  - Funct → Aluctrl: 20/21 add/addu→0; 22/23 sub/subu→1; 24→2; 25→3; 26→4; 27→5; 2A→6; 2B→7; 00→8; 02→9; 03→10; 04→11; 06→12; 07→13 (funct hex).
  - jr (funct 08): RegW=0, PCSrc=11, Aluctrl=0.
- Decoder, I-type (RegDst=1, Alusrc=1, RegW=1 unless noted):
  - addi 08 / addiu 09: sign-ext, ADD
  - slti 0A: sign-ext, SLT; sltiu 0B: sign-ext, SLTU
  - andi 0C / ori 0D / xori 0E: zero-ext, AND/OR/XOR
  - lui 0F: EXTOp=10, PASSB
  - lw 23: sign-ext, ADD, MemR=1, Mem2R=1
  - sw 2B: sign-ext, ADD, MemW=1, RegW=0
  - beq 04 / bne 05: Alusrc=0, sign-ext, SUB, RegW=0, PCSrc 01/10
- Decoder, jumps:
  - j 02: PCSrc=11, RegW=0
  - jal 03: PCSrc=11, RegW=1 (dest forced to r31 outside this block)
- PCWr=1 for every decoded instruction.
- Unknown opcode/funct: all decoder outputs 0, including PCWr (bubble).
- Decoder outputs for unlisted fields are 0.
- EX/MEM register, each rising clk edge, priority rst > flush > load:
  - rst=1 or flush=1: every registered output becomes 0.
  - Otherwise: aluout←C, PCout←PCin, rd2←RD2, op←Op, rd←RD, controls←their _i inputs.
- Register latency 1 cycle; outputs stable between edges. No stall/enable input.
- Reset mid-stream discards the entry; first post-reset load occurs on the next edge with rst=0.

Test Plan:
- Decode sweep: opcode 23 → MemR=1, Mem2R=1, RegW=1, Alusrc=1, EXTOp=01, Aluctrl=0, RegDst=1, PCWr=1. Opcode 3F → all outputs 0.
- Decode R-type: funct 2A → Aluctrl=6, RegW=1, RegDst=0. Funct 08 → PCSrc=11, RegW=0.
- ALU arithmetic/compare:
  - ADD 0xFFFFFFFF+1 → C=0, Zero=1
  - SLT A=0x80000000, B=1 → 1
  - SLTU same operands → 0
  - SUB 5-5 → Zero=1
- ALU shifts:
  - SRA B=0x80000000, sa=4 → 0xF8000000
  - SRLV A=33, B=0x100 → 0x80 (uses A[4:0]=1)
  - PASSB B=0x12340000 → 0x12340000
- EX/MEM load: A=3, B=4, ALUOp=0, RD=9, regw_i=1; edge → aluout=7, rd=9, regw=1 one cycle later. Stable until the next edge.
- Flush/reset priority: flush=1 with valid inputs → all outputs 0 after the edge. rst=1 with flush=0 → 0. Release → next edge loads normally.
